// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix vector RAM: read-mode encodings,
// clear-sequencer state type and default geometry.
package matrix_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DIM    = 8;

  localparam logic RD_MODE_COL = 1'b0;
  localparam logic RD_MODE_ROW = 1'b1;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

  // Index width for a DIM-sized dimension; never narrower than one bit.
  function automatic int idx_width(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

// File: rtl/matrix_clear_seq.sv
// Bulk-clear sequencer: walks a row counter from 0 to DIM-1, one row per cycle,
// and reports busy for exactly DIM cycles.
module matrix_clear_seq
  import matrix_pkg::*;
#(
  parameter int DIM = DEF_DIM,
  localparam int IDX_W = idx_width(DIM)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr_start,
  output logic             clr_busy,
  output logic             clr_row_en,
  output logic [IDX_W-1:0] clr_row,
  output clr_state_t       state
);

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(DIM - 1);

  clr_state_t       state_q, state_d;
  logic [IDX_W-1:0] row_q, row_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLR_IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // clr_start while already running is ignored; the sweep never restarts.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      CLR_IDLE: begin
        if (clr_start) begin
          state_d = CLR_RUN;
          row_d   = '0;
        end
      end
      CLR_RUN: begin
        if (row_q == LAST_ROW) begin
          state_d = CLR_IDLE;
          row_d   = '0;
        end else begin
          row_d = row_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = CLR_IDLE;
        row_d   = '0;
      end
    endcase
  end

  assign clr_busy   = (state_q == CLR_RUN);
  assign clr_row_en = (state_q == CLR_RUN);
  assign clr_row    = row_q;
  assign state      = state_q;

endmodule

// File: rtl/matrix_vector_ram.sv
// DIM x DIM element store with single-element writes and registered row or
// column vector reads, plus a row-sequenced bulk clear.
module matrix_vector_ram
  import matrix_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIM    = DEF_DIM,
  localparam int IDX_W = idx_width(DIM)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_row,
  input  logic [IDX_W-1:0]      wr_col,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_req,
  input  logic                  rd_mode,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DIM*DATA_W-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  clr_start,
  output logic                  clr_busy
);

  localparam logic [IDX_W:0] DIM_L = (IDX_W + 1)'(DIM);

  logic [DATA_W-1:0]     mem [DIM][DIM];
  clr_state_t            clr_state;
  logic                  clr_row_en;
  logic [IDX_W-1:0]      clr_row;
  logic                  idle;
  logic                  wr_fire;
  logic                  rd_fire;
  logic [DIM*DATA_W-1:0] rd_vec;

  matrix_clear_seq #(.DIM(DIM)) u_clear_seq (
    .clock      (clock),
    .reset_n    (reset_n),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy),
    .clr_row_en (clr_row_en),
    .clr_row    (clr_row),
    .state      (clr_state)
  );

  // Handshake: there is no back-pressure. A request is accepted on any edge
  // where rd_req=1, the sequencer is idle and clr_start=0; exactly one
  // rd_valid pulse follows on the next edge. clr_start wins over reads/writes.
  assign idle    = (clr_state == CLR_IDLE);
  assign wr_fire = idle && !clr_start && wr_en &&
                   ({1'b0, wr_row} < DIM_L) && ({1'b0, wr_col} < DIM_L);
  assign rd_fire = idle && !clr_start && rd_req;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          mem[r][c] <= '0;
    end else begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          if (clr_row_en && clr_row == IDX_W'(r))
            mem[r][c] <= '0;
          else if (wr_fire && wr_row == IDX_W'(r) && wr_col == IDX_W'(c))
            mem[r][c] <= wr_data;
        end
      end
    end
  end

  // Index decode by match, so an out-of-range rd_idx selects nothing and reads 0.
  always_comb begin
    rd_vec = '0;
    for (int k = 0; k < DIM; k++) begin
      for (int j = 0; j < DIM; j++) begin
        if (rd_idx == IDX_W'(j))
          rd_vec[k*DATA_W +: DATA_W] = (rd_mode == RD_MODE_ROW) ? mem[j][k] : mem[k][j];
      end
    end
  end

  // rd_vec samples the array before this edge's write lands: read-first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire)
        rd_data <= rd_vec;
    end
  end

endmodule

// File: tb/tb_matrix_vector_ram.sv
// Bench for matrix_vector_ram: an 8x8x16 and a 5x5x8 instance driven with
// directed and random traffic against a plain-array reference model.
module tb_matrix_vector_ram;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic         we0, rq0, md0, cs0, rv0, cb0;
  logic [2:0]   wr0r, wr0c, ri0;
  logic [15:0]  wd0;
  logic [127:0] rd0;

  logic         we1, rq1, md1, cs1, rv1, cb1;
  logic [2:0]   wr1r, wr1c, ri1;
  logic [7:0]   wd1;
  logic [39:0]  rd1;

  matrix_vector_ram dut8 (
    .clock(clock), .reset_n(reset_n),
    .wr_en(we0), .wr_row(wr0r), .wr_col(wr0c), .wr_data(wd0),
    .rd_req(rq0), .rd_mode(md0), .rd_idx(ri0),
    .rd_data(rd0), .rd_valid(rv0),
    .clr_start(cs0), .clr_busy(cb0)
  );

  matrix_vector_ram #(.DATA_W(8), .DIM(5)) dut5 (
    .clock(clock), .reset_n(reset_n),
    .wr_en(we1), .wr_row(wr1r), .wr_col(wr1c), .wr_data(wd1),
    .rd_req(rq1), .rd_mode(md1), .rd_idx(ri1),
    .rd_data(rd1), .rd_valid(rv1),
    .clr_start(cs1), .clr_busy(cb1)
  );

  // Reference model: matrix contents, remaining busy cycles, last delivered vector.
  int           m[2][8][8];
  int           busy_left[2];
  logic [127:0] last_rd[2];
  logic [127:0] exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  bit           obs_busy;

  function automatic int dim_of(input int u);
    return (u == 1) ? 5 : 8;
  endfunction

  function automatic int dw_of(input int u);
    return (u == 1) ? 8 : 16;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    we0 = 0; rq0 = 0; md0 = 0; cs0 = 0; wr0r = 0; wr0c = 0; ri0 = 0; wd0 = 0;
    we1 = 0; rq1 = 0; md1 = 0; cs1 = 0; wr1r = 0; wr1c = 0; ri1 = 0; wd1 = 0;
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      busy_left[u] = 0;
      last_rd[u]   = '0;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          m[u][r][c] = 0;
    end
    exp_q.delete();
  endtask

  // One clock cycle on unit u; called and returns at a falling edge.
  task automatic step(input int u, input bit we, input int wr, input int wc, input int wd,
                      input bit rq, input bit md, input int ri, input bit cs);
    int           d, w, val;
    bit           pre_busy[2];
    bit           rv_exp;
    logic [127:0] ev, got_d;
    logic         got_v, got_b;
    d = dim_of(u);
    w = dw_of(u);
    for (int v = 0; v < 2; v++) begin
      pre_busy[v] = busy_left[v] > 0;
      if (pre_busy[v]) busy_left[v]--;
    end
    rv_exp = 0;
    if (!pre_busy[u]) begin
      if (cs) begin
        busy_left[u] = d;
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            m[u][r][c] = 0;
      end else begin
        if (rq) begin
          ev = '0;
          if (ri < d)
            for (int k = 0; k < d; k++) begin
              val = md ? m[u][ri][k] : m[u][k][ri];
              ev  = ev | (128'(val) << (k * w));
            end
          exp_q.push_back(ev);
          rv_exp = 1;
        end
        if (we && wr < d && wc < d) m[u][wr][wc] = wd & ((1 << w) - 1);
      end
    end
    clear_inputs();
    if (u == 0) begin
      we0 = we; wr0r = 3'(wr); wr0c = 3'(wc); wd0 = 16'(wd);
      rq0 = rq; md0 = md; ri0 = 3'(ri); cs0 = cs;
    end else begin
      we1 = we; wr1r = 3'(wr); wr1c = 3'(wc); wd1 = 8'(wd);
      rq1 = rq; md1 = md; ri1 = 3'(ri); cs1 = cs;
    end
    @(posedge clock);
    @(negedge clock);
    clear_inputs();
    got_v = (u == 0) ? rv0 : rv1;
    got_b = (u == 0) ? cb0 : cb1;
    got_d = (u == 0) ? rd0 : 128'(rd1);
    obs_busy = got_b;
    check("clr_busy", 128'(got_b), 128'(busy_left[u] > 0));
    check("rd_valid", 128'(got_v), 128'(rv_exp));
    if (rv_exp) begin
      ev = exp_q.pop_front();
      check("rd_data", got_d, ev);
      last_rd[u] = ev;
    end else begin
      check("rd_hold", got_d, last_rd[u]);
    end
  endtask

  task automatic idle(input int u, input int n);
    for (int i = 0; i < n; i++) step(u, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic read_all(input int u);
    for (int i = 0; i < dim_of(u); i++) begin
      step(u, 0, 0, 0, 0, 1, 1, i, 0);
      step(u, 0, 0, 0, 0, 1, 0, i, 0);
    end
  endtask

  task automatic random_ops(input int u, input int n, input int idx_max);
    for (int i = 0; i < n; i++)
      step(u, 1'($urandom_range(0, 1)), $urandom_range(0, idx_max), $urandom_range(0, idx_max),
           int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, idx_max), $urandom_range(0, 39) == 0);
  endtask

  int busy_cnt;

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check("reset_busy0", 128'(cb0), 128'(0));
    check("reset_valid0", 128'(rv0), 128'(0));
    check("reset_data0", rd0, 128'(0));
    check("reset_busy1", 128'(cb1), 128'(0));
    check("reset_valid1", 128'(rv1), 128'(0));
    reset_n = 1'b1;
    @(negedge clock);

    step(0, 0, 0, 0, 0, 1, 0, 3, 0);

    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        step(0, 1, r, c, 16 * r + c, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 2, 0);
    check("row2_elem7", rd0[7*16 +: 16], 128'(16'h0027));
    step(0, 0, 0, 0, 0, 1, 0, 5, 0);
    check("col5_elem0", rd0[15:0], 128'(16'h0005));

    step(0, 1, 1, 1, 16'hBEEF, 1, 1, 1, 0);
    check("read_first", rd0[31:16], 128'(16'h0011));
    step(0, 0, 0, 0, 0, 1, 1, 1, 0);
    check("write_seen", rd0[31:16], 128'(16'hBEEF));

    busy_cnt = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    busy_cnt += int'(obs_busy);
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 0, 0, 16'hAAAA, 1, i % 2, i, i == 3);
      busy_cnt += int'(obs_busy);
    end
    for (int i = 0; i < 3; i++) begin
      idle(0, 1);
      busy_cnt += int'(obs_busy);
    end
    check("busy_len", 128'(busy_cnt), 128'(8));
    read_all(0);

    random_ops(0, 300, 7);
    idle(0, 10);

    for (int i = 0; i < 16; i++)
      step(0, 1, $urandom_range(0, 7), $urandom_range(0, 7), int'($urandom_range(1, 65535)), 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 3);
    reset_n = 1'b0;
    #1;
    check("midclr_busy", 128'(cb0), 128'(0));
    check("midclr_valid", 128'(rv0), 128'(0));
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    read_all(0);
    busy_cnt = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    busy_cnt += int'(obs_busy);
    for (int i = 0; i < 10; i++) begin
      idle(0, 1);
      busy_cnt += int'(obs_busy);
    end
    check("busy_len_after_reset", 128'(busy_cnt), 128'(8));

    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        step(1, 1, r, c, int'($urandom_range(1, 255)), 0, 0, 0, 0);
    step(1, 1, 6, 1, 8'h5A, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 6, 0);
    check("oob_row_zero", rd1, 128'(0));
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 0, 0, 1, 1'($urandom_range(0, 1)), i, 0);
    read_all(1);
    random_ops(1, 200, 7);
    idle(1, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/matrix_vector_ram.md
Name: matrix_vector_ram

Overview:
Parametrised DIM x DIM matrix store of DATA_W-bit elements, written one element per cycle and read one full row or column vector per request. Generalises the fixed 8x8, column-only, combinational-read matrix RAM. Adds a row/column read mode, registered read with a valid flag, asynchronous reset, and a sequenced bulk-clear engine. Sits between the matrix loader and the systolic/vector compute datapath.

Parameters:
DATA_W, 16, element width in bits
DIM, 8, matrix dimension (rows = columns = DIM), 2..64
IDX_W, $clog2(DIM) (min 1), width of row/column index ports (derived, not overridden)

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
wr_en  in  1  element write strobe
wr_row  in  IDX_W  write row index
wr_col  in  IDX_W  write column index
wr_data  in  DATA_W  write element
rd_req  in  1  vector read request
rd_mode  in  1  0 = column read, 1 = row read
rd_idx  in  IDX_W  row or column to read
rd_data  out  DIM*DATA_W  vector; element k at [k*DATA_W +: DATA_W]
rd_valid  out  1  rd_data valid this cycle
clr_start  in  1  start bulk clear
clr_busy  out  1  clear in progress

Behaviour:
- Storage is word[r][c], r,c in 0..DIM-1.
- Reset (reset_n=0, async): all word = 0, rd_data = 0, rd_valid = 0, clr_busy = 0, FSM = IDLE.
- Write: on a rising edge with wr_en=1, clr_busy=0 and wr_row<DIM and wr_col<DIM, set word[wr_row][wr_col] <= wr_data. Otherwise no change.
- Read: rd_req=1 and clr_busy=0 at edge N gives rd_valid=1 at edge N+1 (1-cycle latency).
  - Row mode: element k = word[rd_idx][k].
  - Column mode: element k = word[k][rd_idx].
- Back-to-back reads are sustained, one per cycle.
- rd_valid is a single-cycle pulse per accepted request. rd_data holds its last value while rd_valid=0.
- Out-of-range read (rd_idx>=DIM, only possible when DIM is not a power of 2): accepted, rd_valid=1, rd_data=0.
- Read and write to the same element in the same cycle: read returns the pre-write content (read-first). The write is visible from the next read on.
- Clear FSM:
  - IDLE: clr_start=1 -> CLEAR, row counter = 0, clr_busy=1 from the next cycle.
  - CLEAR: each cycle zero all of row[counter], then counter+1. After row DIM-1 is cleared -> IDLE, clr_busy=0 the cycle after the last row.
  - Total busy duration is exactly DIM cycles.
- While clr_busy=1, wr_en and rd_req are ignored: no write, no rd_valid. clr_start during CLEAR is ignored (no restart).
- In IDLE, clr_start has priority over writes and reads in the same cycle: that cycle's wr_en and rd_req are dropped.
- Reset asserted mid-clear: immediate return to IDLE, whole array zero.

Decomposition:
- Shared package matrix_pkg:
  - Mode constants RD_MODE_COL=1'b0, RD_MODE_ROW=1'b1.
  - FSM state typedef clr_state_t {CLR_IDLE, CLR_RUN}.
  - Default DATA_W/DIM constants.
- One sub-module, matrix_clear_seq: clear FSM plus row counter. Outputs clr_busy, clr_row_en and clr_row. The top level owns the storage array and the read/write paths.

Test Plan:
- After reset, column read of idx 3 -> rd_valid at the next edge, all 8 elements 0x0000. clr_busy=0.
- Write word[r][c]=16*r+c for all 64 elements, then row read idx 2 -> elements 0x20..0x27. Column read idx 5 -> elements 0x05,0x15,...,0x75, k=0 in the LSBs.
- Same cycle: write word[1][1]=0xBEEF and row read idx 1 -> element1=0x0011. Next-cycle row read -> element1=0xBEEF.
- clr_start, then wr_en(0,0,0xAAAA) and rd_req during busy -> clr_busy high exactly 8 cycles, no rd_valid. A subsequent read of every row and column returns all zeros.
- Pulse reset_n low at clear cycle 3 -> clr_busy=0 and rd_valid=0 immediately. After release, all reads return 0 and a new clr_start runs the full 8 cycles.
- DIM=5, DATA_W=8: write (6,1) is ignored; row read idx 6 -> rd_valid=1, rd_data=0. Sustained reads on 5 consecutive cycles -> 5 consecutive rd_valid pulses with correct vectors.
